// File: rtl/reg_share_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : reg_arb_pkg
// Purpose  : Shared types and default constants for reg_share_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reg_arb_pkg;

  // Write transaction sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam int NREQ_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 4;
  localparam int IDW_DEFAULT   = 2;

endpackage : reg_arb_pkg

`default_nettype wire

// File: rtl/reg_share_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// Module   : rr_picker
// Purpose  : Combinational round-robin selector. Returns the first set request
//            bit at or above the pointer, wrapping modulo NREQ. Pointer values
//            outside 0..NREQ-1 are treated as 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  int          ptr_eff;
  int          cand;
  logic [NREQ-1:0] req_rot;

  // Scan upward from the effective pointer; first hit wins
  always_comb begin
    found   = 1'b0;
    idx     = '0;
    cand    = 0;
    req_rot = '0;
    ptr_eff = (int'(ptr) >= NREQ) ? 0 : int'(ptr);
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_eff + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      req_rot = req >> cand;
      if (!found && req_rot[0]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule : rr_picker

`default_nettype wire

// File: rtl/reg_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : reg_share_arbiter
// Purpose  : Round-robin write controller sharing one WIDTH-bit register
//            between NREQ requesters through a grant/ack handshake.
//            Optional macro REG_ARB_OWNER_EN adds last_owner and valid outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int IDW   = IDW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
`ifdef REG_ARB_OWNER_EN
  ,
  output logic [IDW-1:0]        last_owner,
  output logic                  valid
`endif
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]  data_q;
  logic              run_q;
  logic              load;
  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [NREQ-1:0]   owner_oh;
  logic              owner_req;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_picker (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_oh  = NREQ'(1) << owner_q;
  assign owner_req = |(req & owner_oh);

  // Release from reset takes effect one edge later, so arbitration starts on
  // the second edge after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // FSM, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: pick in IDLE, commit or abort in GRANT, advance in ACK
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_q && pick_found) begin
          owner_d = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (owner_req) begin
          load    = 1'b1;
          state_d = ACK;
        end else begin
          // Owner withdrew: no write, pointer stays put
          state_d = IDLE;
        end
      end
      ACK: begin
        ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shared storage register; async clear discards any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= wdata[owner_q*WIDTH +: WIDTH];
    end
  end

`ifdef REG_ARB_OWNER_EN
  logic [IDW-1:0] last_owner_q;
  logic           valid_q;

  // Record who committed the latest write; valid is sticky until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= '0;
      valid_q      <= 1'b0;
    end else if (load) begin
      last_owner_q <= owner_q;
      valid_q      <= 1'b1;
    end
  end

  assign last_owner = last_owner_q;
  assign valid      = valid_q;
`endif

  assign gnt  = (state_q == GRANT) ? owner_oh : '0;
  assign ack  = (state_q == ACK)   ? owner_oh : '0;
  assign q    = data_q;
  assign busy = (state_q != IDLE);

endmodule : reg_share_arbiter

`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_reg_share_arbiter
// Purpose  : Self-checking bench for reg_share_arbiter (NREQ=4, WIDTH=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [3:0]  q;
  logic        busy;
`ifdef REG_ARB_OWNER_EN
  logic [1:0]  last_owner;
  logic        valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] ack;
    logic [3:0] q;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  always #5 clk = ~clk;

  reg_share_arbiter #(
    .NREQ  (4),
    .WIDTH (4),
    .IDW   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
`ifdef REG_ARB_OWNER_EN
    ,
    .last_owner (last_owner),
    .valid      (valid)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic exp_t mk(input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    e.ack = a;
    e.q   = d;
    return e;
  endfunction

  // Scoreboard monitor: every ack pulse must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: got ack=%b q=%h expected no ack", ack, q);
      end else begin
        m_e = sb.pop_front();
        chk("sb_ack", ack, m_e.ack);
        chk("sb_q", q, m_e.q);
        chk("sb_gnt_low_in_ack", gnt, 0);
      end
    end
  end

  // Safety bound on total run time
  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    wdata = 16'($urandom);

    // Reset holds everything at zero despite active requests
    repeat (3) begin
      @(negedge clk);
      chk("reset_q", q, 0);
      chk("reset_gnt", gnt, 0);
      chk("reset_ack", ack, 0);
      chk("reset_busy", busy, 0);
    end
`ifdef REG_ARB_OWNER_EN
    chk("reset_last_owner", last_owner, 0);
    chk("reset_valid", valid, 0);
`endif

    // Round robin: data equals requester index, order 0,1,2,3,0
    wdata = 16'h3210;
    for (int i = 0; i < 5; i++) sb.push_back(mk(oh(i % 4), 4'(i % 4)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    chk("release_holdoff_gnt", gnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("rr_gnt", gnt, oh(i % 4));
      chk("rr_busy", busy, 1);
      tick(1);
      chk("rr_q", q, i % 4);
      chk("rr_ack", ack, oh(i % 4));
      if (i == 4) req = 4'b0000;
      tick(1);
      chk("rr_idle", busy, 0);
    end

    // Abort: owner 1 drops its request during GRANT; pointer must stay at 1
    wdata = 16'h3A50;
    req   = 4'b0010;
    tick(1);
    chk("abort_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick(1);
    chk("abort_ack", ack, 0);
    chk("abort_q", q, 0);
    chk("abort_busy", busy, 0);
    req = 4'b0011;
    sb.push_back(mk(4'b0010, 4'h5));
    tick(1);
    chk("regrant_gnt", gnt, 4'b0010);
    tick(1);
    chk("regrant_q", q, 4'h5);
    req = 4'b0000;
    tick(1);

    // Single request from requester 2
    req = 4'b0100;
    sb.push_back(mk(4'b0100, 4'hA));
    tick(1);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_ack_low", ack, 0);
    tick(1);
    chk("single_q", q, 4'hA);
    chk("single_ack", ack, 4'b0100);
    chk("single_gnt_low", gnt, 0);
    req = 4'b0000;
    tick(1);
    chk("single_idle", busy, 0);

    // Async reset in the ACK cycle after loading 7
    wdata = 16'h3750;
    req   = 4'b0100;
    sb.push_back(mk(4'b0100, 4'h7));
    tick(1);
    chk("arst_gnt", gnt, 4'b0100);
    tick(1);
    chk("arst_loaded", q, 4'h7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_ack", ack, 0);
    chk("arst_busy", busy, 0);
    req   = 4'b1001;
    wdata = 16'h3758;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back(mk(4'b0001, 4'h8));
    tick(1);
    chk("arst_holdoff_gnt", gnt, 0);
    tick(1);
    chk("arst_ptr_zero_gnt", gnt, 4'b0001);
`ifdef REG_ARB_OWNER_EN
    chk("valid_before_write", valid, 0);
`endif
    tick(1);
    chk("arst_after_q", q, 4'h8);
    req = 4'b0000;
    tick(1);

`ifdef REG_ARB_OWNER_EN
    // Owner tracking: requester 3 then requester 1
    req = 4'b1000;
    sb.push_back(mk(4'b1000, 4'h3));
    tick(2);
    chk("owner_last3", last_owner, 3);
    chk("owner_valid1", valid, 1);
    req = 4'b0000;
    tick(1);
    req = 4'b0010;
    sb.push_back(mk(4'b0010, 4'h5));
    tick(2);
    chk("owner_last1", last_owner, 1);
    chk("owner_valid2", valid, 1);
    req = 4'b0000;
    tick(2);
    chk("owner_valid_held", valid, 1);
`endif

    tick(2);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_share_arbiter

`default_nettype wire

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin write controller that shares one WIDTH-bit storage register (the team's D-type Register, q updated on clk rising edge) between NREQ requesters.
- Sequences each write through a grant/ack handshake, so exactly one requester's data is loaded per transaction.
- Drives the shared register's output q directly to all consumers.
- Sits between requester blocks and the Register datapath; the Register itself carries no enable, so this block owns its load timing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, storage register width in bits.
- IDW, 2, requester index width, equal to clog2(NREQ).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level, held until ack.
- wdata  input  NREQ*WIDTH  requester i's data at bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant, high only in GRANT state.
- ack  output  NREQ  one-hot, one-cycle pulse in ACK state; write committed.
- q  output  WIDTH  shared register contents.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: async on rst_n low.
  - state=IDLE; q=0; gnt=0; ack=0; busy=0; rr pointer=0.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If any req bit is high, select the first set bit searching from the pointer upward, wrapping modulo NREQ.
  - Latch its index as owner; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - gnt[owner]=1.
  - If req[owner] is still high: load q <= wdata slice of owner on this edge; go to ACK.
  - If req[owner] has dropped: abort. No write; pointer unchanged; go to IDLE.
- ACK:
  - ack[owner]=1 for exactly one cycle; q already holds new data.
  - Pointer <= owner+1, wrapping NREQ-1 -> 0.
  - Always go to IDLE.
- Latency: req sampled at edge 0; gnt visible after edge 1; q updated and ack visible after edge 2; idle after edge 3.
  - Minimum 3 cycles per transaction.
  - Back-to-back requests are regranted the cycle after ACK.
- Fairness: the requester just served has the lowest priority next round. Any continuously requesting requester is served within NREQ transactions.
- Requests arriving while busy are not lost; they are evaluated on the next IDLE cycle.
- req changes on non-owner bits during GRANT or ACK are ignored.
- gnt and ack are never high simultaneously; at most one bit of each is set.
- Reset mid-transaction: immediate return to reset values, including q=0. A partially granted write is discarded.
- Unused pointer values (NREQ not a power of 2) are treated as 0.

Optional Feature:
- Macro: REG_ARB_OWNER_EN.
- Defined:
  - Adds output last_owner [IDW-1:0], reset 0.
  - Updated to owner on the same edge that loads q.
  - Adds output valid, reset 0; set on the first committed write and held until reset.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package reg_arb_pkg holds:
  - state enum {IDLE, GRANT, ACK};
  - default constants for NREQ, WIDTH, IDW.
- One sub-module, rr_picker: combinational.
  - Inputs: req and pointer.
  - Outputs: found flag and index.
  - Reusable by other shared-resource arbiters.
- The storage register is implemented inline as a clocked process with async clear. The existing Register module has no reset or enable, so it is not reused.

Test Plan:
- Reset: rst_n=0 while req=4'b1111 and random wdata -> q=0, gnt=0, ack=0, busy=0 throughout; first grant appears 2 edges after release.
- Single request: req=4'b0100, wdata[11:8]=4'hA -> gnt=4'b0100 after edge 1; q=4'hA and ack=4'b0100 after edge 2; busy low after edge 3.
- Round-robin: req=4'b1111 held, each requester's data = its index -> ack order 0,1,2,3,0; q sequence 0,1,2,3,0; one write per 3 cycles.
- Abort: req=4'b0010, drop req[1] in the GRANT cycle -> no ack, q unchanged; next grant with req=4'b0011 goes to requester 1 (pointer not advanced).
- Async reset mid-transaction: pull rst_n low in the ACK cycle after q loaded 4'h7 -> q=0 within the same cycle, no clock edge needed; pointer=0.
- REG_ARB_OWNER_EN: write from requester 3 then requester 1 -> last_owner=3 then 1; valid goes high at the first write and stays high.
